// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the memory-access stage
package mem_pkg;

  localparam int LD_LB  = 0;
  localparam int LD_LH  = 1;
  localparam int LD_LW  = 2;
  localparam int LD_LBU = 3;
  localparam int LD_LHU = 4;

  localparam int ST_SB = 0;
  localparam int ST_SH = 1;
  localparam int ST_SW = 2;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane replication, byte enables, load extraction and misalign check
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        i_access,
  input  logic        i_is_store,
  input  logic [4:0]  i_loadsrc,
  input  logic [2:0]  i_storesrc,
  input  logic [1:0]  i_adr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_load_data,
  output logic        o_misalign
);

  size_e       w_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Stores win over loads; any store encoding that is not sb/sh acts as sw.
  always_comb begin
    w_size = SZ_W;
    if (i_is_store) begin
      if (i_storesrc == 3'b001)      w_size = SZ_B;
      else if (i_storesrc == 3'b010) w_size = SZ_H;
      else                           w_size = SZ_W;
    end else if (i_loadsrc[LD_LB] || i_loadsrc[LD_LBU]) begin
      w_size = SZ_B;
    end else if (i_loadsrc[LD_LH] || i_loadsrc[LD_LHU]) begin
      w_size = SZ_H;
    end
  end

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (w_size)
      SZ_B: begin
        o_be    = 4'b0001 << i_adr;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_be    = i_adr[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  assign o_misalign = i_access &
                      (((w_size == SZ_H) && i_adr[0]) ||
                       ((w_size == SZ_W) && (i_adr != 2'b00)));

  assign w_byte = i_rdata[{i_adr, 3'b000} +: 8];
  assign w_half = i_rdata[{i_adr[1], 4'b0000} +: 16];

  always_comb begin
    o_load_data = i_rdata;
    if (i_loadsrc[LD_LB])       o_load_data = {{24{w_byte[7]}}, w_byte};
    else if (i_loadsrc[LD_LBU]) o_load_data = {24'd0, w_byte};
    else if (i_loadsrc[LD_LH])  o_load_data = {{16{w_half[15]}}, w_half};
    else if (i_loadsrc[LD_LHU]) o_load_data = {16'd0, w_half};
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - data-memory access FSM with stall, timeout and lane handling
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memwriteM,
  input  logic [4:0]        loadsrcM,
  input  logic [2:0]        StoreSrcM,
  input  logic [1:0]        AdrM,
  input  logic [31:0]       aluresultM,
  input  logic [31:0]       writeDataM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              stallM,
  output logic [31:0]       loaddataM,
  output logic              misalignM,
  output logic              bus_errM
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_loaddata;
  logic             r_bus_err;

  logic        w_access;
  logic        w_valid;
  logic        w_expired;
  logic [31:0] w_load_ext;
  logic        w_unused_adr;

  assign w_access  = memwriteM | (|loadsrcM);
  assign w_valid   = w_access & ~misalignM;
  assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  mem_lane_align u_lane (
    .i_access    (w_access),
    .i_is_store  (memwriteM),
    .i_loadsrc   (loadsrcM),
    .i_storesrc  (StoreSrcM),
    .i_adr       (AdrM),
    .i_wdata     (writeDataM),
    .i_rdata     (dmem_rdata),
    .o_wdata     (dmem_wdata),
    .o_be        (dmem_be),
    .o_load_data (w_load_ext),
    .o_misalign  (misalignM)
  );

  assign dmem_addr    = {aluresultM[ADDR_W-1:2], 2'b00};
  assign dmem_we      = memwriteM;
  assign w_unused_adr = ^aluresultM[1:0];
  assign loaddataM    = r_loaddata;
  assign bus_errM     = r_bus_err;

  // A granted store finishes in the request cycle, so it never stalls.
  always_comb begin
    dmem_req = 1'b0;
    stallM   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          dmem_req = ~w_expired;
          stallM   = w_expired | ~(memwriteM & dmem_gnt);
        end
      end
      S_WAIT:  stallM = 1'b1;
      default: stallM = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_loaddata <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_valid) begin
            r_cnt <= '0;
          end else if (w_expired) begin
            r_state    <= S_DONE;
            r_bus_err  <= 1'b1;
            r_loaddata <= '0;
            r_cnt      <= '0;
          end else if (dmem_gnt && memwriteM) begin
            r_cnt <= '0;
          end else begin
            if (dmem_gnt) r_state <= S_WAIT;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (w_expired) begin
            r_state    <= S_DONE;
            r_bus_err  <= 1'b1;
            r_loaddata <= '0;
            r_cnt      <= '0;
          end else if (dmem_rvalid) begin
            r_state    <= S_DONE;
            r_loaddata <= w_load_ext;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        memwriteM;
  logic [4:0]  loadsrcM;
  logic [2:0]  StoreSrcM;
  logic [1:0]  AdrM;
  logic [31:0] aluresultM;
  logic [31:0] writeDataM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stallM;
  logic [31:0] loaddataM;
  logic        misalignM;
  logic        bus_errM;

  int errors = 0;
  int checks = 0;

  logic [4:0]  lv_src  [5] = '{5'b00001, 5'b01000, 5'b00010, 5'b10000, 5'b00100};
  logic [1:0]  lv_adr  [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
  logic [31:0] lv_rd   [5] = '{32'h80FF0000, 32'h80FF0000, 32'h80011234, 32'h0000F00D, 32'hDEADBEEF};
  logic [31:0] lv_exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F00D, 32'hDEADBEEF};
  logic [3:0]  lv_be   [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b1111};

  mem_access_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .memwriteM(memwriteM), .loadsrcM(loadsrcM),
    .StoreSrcM(StoreSrcM), .AdrM(AdrM), .aluresultM(aluresultM), .writeDataM(writeDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .stallM(stallM), .loaddataM(loaddataM),
    .misalignM(misalignM), .bus_errM(bus_errM)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    memwriteM = 0; loadsrcM = 0; StoreSrcM = 0; AdrM = 0; aluresultM = 0;
    writeDataM = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmem_req); end
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stallM); end
    checks++; if (loaddataM !== 32'h0) begin errors++; $display("FAIL reset_loaddata: got %h want 0", loaddataM); end
    checks++; if (bus_errM !== 1'b0) begin errors++; $display("FAIL reset_buserr: got %b want 0", bus_errM); end
    rst = 1;
  endtask

  task automatic test_store();
    @(negedge clk);
    memwriteM = 1; StoreSrcM = 3'b100; aluresultM = 32'h100; AdrM = 2'd0;
    writeDataM = 32'hA1B2C3D4; dmem_gnt = 1;
    #1;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL sw_req: got %b want 1", dmem_req); end
    checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b want 1", dmem_we); end
    checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL sw_addr: got %h want 00000100", dmem_addr); end
    checks++; if (dmem_be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b want 1111", dmem_be); end
    checks++; if (dmem_wdata !== 32'hA1B2C3D4) begin errors++; $display("FAIL sw_wdata: got %h want a1b2c3d4", dmem_wdata); end
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL sw_stall: got %b want 0", stallM); end
    @(negedge clk);
    StoreSrcM = 3'b001; aluresultM = 32'h102; AdrM = 2'd2; writeDataM = 32'h000000EE;
    #1;
    checks++; if (dmem_be !== 4'b0100) begin errors++; $display("FAIL sb_be: got %b want 0100", dmem_be); end
    checks++; if (dmem_wdata !== 32'hEEEEEEEE) begin errors++; $display("FAIL sb_wdata: got %h want eeeeeeee", dmem_wdata); end
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL sb_stall: got %b want 0", stallM); end
    @(negedge clk);
    StoreSrcM = 3'b010; aluresultM = 32'h106; AdrM = 2'd2; writeDataM = 32'hFFFF1234; dmem_gnt = 0;
    #1;
    checks++; if (dmem_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", dmem_be); end
    checks++; if (dmem_wdata !== 32'h12341234) begin errors++; $display("FAIL sh_wdata: got %h want 12341234", dmem_wdata); end
    checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL sh_nognt_stall: got %b want 1", stallM); end
    @(negedge clk);
    dmem_gnt = 1;
    #1;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL sh_retry_req: got %b want 1", dmem_req); end
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL sh_retry_stall: got %b want 0", stallM); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_load();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      loadsrcM = lv_src[i]; AdrM = lv_adr[i]; aluresultM = {28'h000020, 2'b00, lv_adr[i]};
      dmem_gnt = 1;
      #1;
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin errors++; $display("FAIL ld%0d_req: got req=%b we=%b want req=1 we=0", i, dmem_req, dmem_we); end
      checks++; if (dmem_be !== lv_be[i]) begin errors++; $display("FAIL ld%0d_be: got %b want %b", i, dmem_be, lv_be[i]); end
      checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL ld%0d_stall0: got %b want 1", i, stallM); end
      @(negedge clk);
      dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = lv_rd[i];
      #1;
      checks++; if (stallM !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL ld%0d_wait: got stall=%b req=%b want stall=1 req=0", i, stallM, dmem_req); end
      @(negedge clk);
      dmem_rvalid = 0;
      #1;
      checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL ld%0d_done_stall: got %b want 0", i, stallM); end
      checks++; if (loaddataM !== lv_exp[i]) begin errors++; $display("FAIL ld%0d_data: got %h want %h", i, loaddataM, lv_exp[i]); end
      clear_inputs();
    end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    loadsrcM = 5'b00010; AdrM = 2'd1; aluresultM = 32'h301;
    #1;
    checks++; if (misalignM !== 1'b1) begin errors++; $display("FAIL lh_mis_flag: got %b want 1", misalignM); end
    checks++; if (dmem_req !== 1'b0 || stallM !== 1'b0) begin errors++; $display("FAIL lh_mis_req: got req=%b stall=%b want 0 0", dmem_req, stallM); end
    @(negedge clk);
    loadsrcM = 0; memwriteM = 1; StoreSrcM = 3'b100; AdrM = 2'd2; aluresultM = 32'h302;
    #1;
    checks++; if (misalignM !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL sw_mis: got mis=%b req=%b want 1 0", misalignM, dmem_req); end
    @(negedge clk);
    clear_inputs();
    loadsrcM = 5'b00100; AdrM = 2'd0; aluresultM = 32'h300; dmem_gnt = 1;
    #1;
    checks++; if (misalignM !== 1'b0 || dmem_req !== 1'b1 || stallM !== 1'b1) begin errors++; $display("FAIL lw_ok: got mis=%b req=%b stall=%b want 0 1 1", misalignM, dmem_req, stallM); end
    @(negedge clk);
    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    dmem_rvalid = 0;
    #1;
    checks++; if (loaddataM !== 32'h12345678 || stallM !== 1'b0) begin errors++; $display("FAIL lw_ok_done: got data=%h stall=%b want 12345678 0", loaddataM, stallM); end
    clear_inputs();
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    loadsrcM = 5'b00100; AdrM = 2'd0; aluresultM = 32'h400; dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    #1;
    checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL rstw_inwait: got stall=%b want 1", stallM); end
    #1;
    rst = 0; loadsrcM = 0;
    #1;
    checks++; if (stallM !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL rstw_idle: got stall=%b req=%b want 0 0", stallM, dmem_req); end
    checks++; if (loaddataM !== 32'h0) begin errors++; $display("FAIL rstw_data: got %h want 0", loaddataM); end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    dmem_rvalid = 1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL rstw_rvalid_stall: got %b want 0", stallM); end
    @(negedge clk);
    dmem_rvalid = 0;
    #1;
    checks++; if (loaddataM !== 32'h0 || stallM !== 1'b0) begin errors++; $display("FAIL rstw_ignored: got data=%h stall=%b want 0 0", loaddataM, stallM); end
    clear_inputs();
  endtask

  task automatic test_timeout();
    @(negedge clk);
    loadsrcM = 5'b00100; AdrM = 2'd0; aluresultM = 32'h500; dmem_gnt = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (dmem_req !== 1'b1 || stallM !== 1'b1 || bus_errM !== 1'b0) begin errors++; $display("FAIL to_req%0d: got req=%b stall=%b err=%b want 1 1 0", c, dmem_req, stallM, bus_errM); end
      @(negedge clk);
    end
    #1;
    checks++; if (dmem_req !== 1'b0 || stallM !== 1'b1) begin errors++; $display("FAIL to_drop: got req=%b stall=%b want 0 1", dmem_req, stallM); end
    @(negedge clk);
    #1;
    checks++; if (bus_errM !== 1'b1 || stallM !== 1'b0 || loaddataM !== 32'h0) begin errors++; $display("FAIL to_done: got err=%b stall=%b data=%h want 1 0 0", bus_errM, stallM, loaddataM); end
    clear_inputs();
    @(negedge clk);
    #1;
    checks++; if (bus_errM !== 1'b0 || stallM !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL to_idle: got err=%b stall=%b req=%b want 0 0 0", bus_errM, stallM, dmem_req); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misalign();
    test_reset_in_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
